// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes the immediate, format and legality of an RV32/RV64
// instruction (optionally RVC) at the moment it is accepted. The decoded result
// is held in a 2-entry skid FIFO that delivers entries in order.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of buffered and same-cycle incoming entries
//   in_valid/in_ready upstream handshake; in_ready depends on registered state only
//   in_inst, in_pc    instruction word (compressed in [15:0]) and its address
//   out_valid/out_ready downstream handshake on the head entry
//   out_imm, out_pc   decoded immediate and passed-through PC (0 while out_valid=0)
//   out_fmt           0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
//   out_rvc           entry came from a compressed word
//   out_illegal       encoding not recognised by this decoder
module imm_decode_stage #(
    parameter int unsigned XLEN   = 32,
    parameter bit          RVC_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic            out_rvc,
    output logic            out_illegal
);

    localparam int unsigned FMT_W = 3;

    localparam logic [FMT_W-1:0] FMT_R = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J = 3'd5;
    localparam logic [FMT_W-1:0] FMT_Z = 3'd6;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [FMT_W-1:0] fmt;
        logic             rvc;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    entry_t          r_head;
    entry_t          r_tail;
    entry_t          w_dec;
    entry_t          w_out;
    logic [XLEN-1:0] w_imm;
    logic [FMT_W-1:0] w_fmt;
    logic            w_rvc;
    logic            w_ill;
    logic            w_push;
    logic            w_pop;

    // Immediate/format decode of the incoming word; illegal encodings leave imm/fmt at 0
    always_comb begin
        w_imm = '0;
        w_fmt = FMT_R;
        w_rvc = 1'b0;
        w_ill = 1'b0;
        if (in_inst[1:0] == 2'b11) begin
            case (in_inst[6:2])
                OPC_LUI, OPC_AUIPC: begin
                    w_fmt = FMT_U;
                    w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
                end
                OPC_JAL: begin
                    w_fmt = FMT_J;
                    w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                           in_inst[30:21], 1'b0}));
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                    w_fmt = FMT_I;
                    w_imm = XLEN'($signed(in_inst[31:20]));
                end
                OPC_BRANCH: begin
                    w_fmt = FMT_B;
                    w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                           in_inst[11:8], 1'b0}));
                end
                OPC_STORE: begin
                    w_fmt = FMT_S;
                    w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                end
                OPC_SYSTEM: begin
                    w_fmt = FMT_Z;
                    w_imm = XLEN'(in_inst[19:15]);
                end
                OPC_OP: begin
                    w_fmt = FMT_R;
                end
                default: begin
                    w_ill = 1'b1;
                end
            endcase
        end else if (!RVC_EN) begin
            w_ill = 1'b1;
        end else begin
            w_rvc = 1'b1;
            // Quadrant and funct3 together select the compressed form
            case ({in_inst[1:0], in_inst[15:13]})
                5'b01_000, 5'b01_010: begin
                    w_fmt = FMT_I;
                    w_imm = XLEN'($signed({in_inst[12], in_inst[6:2]}));
                end
                5'b01_011: begin
                    // rd=2 is C.ADDI16SP and rd=0 is reserved; neither is handled here
                    if (in_inst[11:7] != 5'd0 && in_inst[11:7] != 5'd2) begin
                        w_fmt = FMT_U;
                        w_imm = XLEN'($signed({in_inst[12], in_inst[6:2], 12'b0}));
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                5'b01_101: begin
                    w_fmt = FMT_J;
                    w_imm = XLEN'($signed({in_inst[12], in_inst[8], in_inst[10:9],
                                           in_inst[6], in_inst[7], in_inst[2],
                                           in_inst[11], in_inst[5:3], 1'b0}));
                end
                5'b01_110, 5'b01_111: begin
                    w_fmt = FMT_B;
                    w_imm = XLEN'($signed({in_inst[12], in_inst[6:5], in_inst[2],
                                           in_inst[11:10], in_inst[4:3], 1'b0}));
                end
                5'b00_010: begin
                    w_fmt = FMT_I;
                    w_imm = XLEN'({in_inst[5], in_inst[12:10], in_inst[6], 2'b00});
                end
                5'b00_110: begin
                    w_fmt = FMT_S;
                    w_imm = XLEN'({in_inst[5], in_inst[12:10], in_inst[6], 2'b00});
                end
                default: begin
                    w_ill = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_dec.imm     = w_imm;
        w_dec.pc      = in_pc;
        w_dec.fmt     = w_fmt;
        w_dec.rvc     = w_rvc;
        w_dec.illegal = w_ill;
    end

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // FIFO control and storage; head is always the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_state <= ST_ONE;
                        r_head  <= w_dec;
                    end
                end
                ST_ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            r_state <= ST_FULL;
                            r_tail  <= w_dec;
                        end
                        2'b01: begin
                            r_state <= ST_EMPTY;
                        end
                        2'b11: begin
                            r_head <= w_dec;
                        end
                        default: begin
                            r_state <= ST_ONE;
                        end
                    endcase
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_state <= ST_ONE;
                        r_head  <= r_tail;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Stale head contents are masked so idle outputs read zero
    assign w_out = out_valid ? r_head : '0;

    assign out_imm     = w_out.imm;
    assign out_pc      = w_out.pc;
    assign out_fmt     = w_out.fmt;
    assign out_rvc     = w_out.rvc;
    assign out_illegal = w_out.illegal;

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32, immediate/PC width; legal values 32 and 64.
REQ-002 SHALL provide parameter RVC_EN, default 0, enabling 16-bit compressed-instruction immediate expansion.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide port flush  input  1  synchronous discard of all buffered and incoming entries.
REQ-006 SHALL provide port in_valid  input  1  upstream entry present.
REQ-007 SHALL provide port in_ready  output  1  stage accepts an entry this cycle.
REQ-008 SHALL provide port in_inst  input  32  instruction word; compressed words occupy bits [15:0].
REQ-009 SHALL provide port in_pc  input  XLEN  instruction address, passed through.
REQ-010 SHALL provide port out_valid  output  1  head entry valid.
REQ-011 SHALL provide port out_ready  input  1  downstream consumes head.
REQ-012 SHALL provide ports out_imm (XLEN), out_pc (XLEN), out_fmt (3), out_rvc (1), out_illegal (1), all outputs.

Function
REQ-013 SHALL hold a 2-entry FIFO with states EMPTY, ONE, FULL; push = in_valid&in_ready, pop = out_valid&out_ready.
REQ-014 SHALL drive in_ready = (state != FULL) from registered state only; no combinational path from out_ready.
REQ-015 SHALL decode at push and store decoded result; an entry pushed at edge N into EMPTY is on outputs from cycle N+1.
REQ-016 Transitions: EMPTY-push->ONE; ONE-push-only->FULL; ONE-pop-only->EMPTY; ONE push&pop->ONE; FULL-pop->ONE; all others hold.
REQ-017 SHALL preserve FIFO order; outputs show head entry; out_valid = (state != EMPTY).
REQ-018 out_fmt encoding: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm); 7 unused.
REQ-019 32-bit forms (in_inst[1:0]=11), selected by opcode [6:2]: LUI/AUIPC U {[31:12],12'b0}; JAL J {[31],[19:12],[20],[30:21],0}; JALR/LOAD/OP-IMM I [31:20]; BRANCH B {[31],[7],[30:25],[11:8],0}; STORE S {[31:25],[11:7]}; SYSTEM Z zero-extended [19:15]; OP fmt R imm 0.
REQ-020 All non-Z immediates SHALL be sign-extended from the top encoded bit to XLEN (U included when XLEN=64).
REQ-021 Unrecognised 32-bit opcode SHALL set out_illegal=1, out_fmt=0, out_imm=0.
REQ-022 RVC_EN=1, in_inst[1:0]!=11: out_rvc=1; C.ADDI/C.LI I sext{[12],[6:2]}; C.LUI (rd!=0,2) U sext{[12],[6:2],12'b0}; C.J J sext{[12],[8],[10:9],[6],[7],[2],[11],[5:3],0}; C.BEQZ/C.BNEZ B sext{[12],[6:5],[2],[11:10],[4:3],0}; C.LW I / C.SW S zext{[5],[12:10],[6],00}.
REQ-023 Any other compressed encoding, or any compressed word when RVC_EN=0, SHALL set out_illegal=1, out_fmt=0, out_imm=0.
REQ-024 flush SHALL force EMPTY at that edge and discard a same-cycle push; flush overrides push and pop.
REQ-025 Data registers of non-valid entries are don't-care; outputs SHALL read 0 while out_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force EMPTY: out_valid=0, in_ready=1, out_imm/out_pc/out_fmt/out_rvc/out_illegal=0.
REQ-027 Reset mid-operation SHALL drop all buffered entries; first push after rst_n rises appears next cycle.

Verification
REQ-028 XLEN=32, push 0xFFDFF06F (jal x0,-4), out_ready=1 -> next cycle out_imm=0xFFFFFFFC, out_fmt=5, out_illegal=0.
REQ-029 XLEN=64, push 0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4; push 0x3002D073 (csrrwi) -> out_imm=5, out_fmt=6.
REQ-030 out_ready=0, push A,B,C back-to-back -> in_ready=0 after B, C held; raise out_ready -> A,B,C emitted in order, one per cycle.
REQ-031 RVC_EN=1, push 0x0000557D (c.li x10,-1) -> out_imm=0xFFFFFFFF, out_fmt=1, out_rvc=1; RVC_EN=0 same word -> out_illegal=1, out_imm=0.
REQ-032 FULL state, in_valid=1, flush=1 -> next cycle out_valid=0, in_ready=1, no entry emitted; rst_n pulse low while ONE -> out_valid=0 immediately.
